// File: rtl/uart_rx_word_packer.sv
// -----------------------------------------------------------------------------
// uart_rx_word_packer
//
// Receives UART bytes on an asynchronous serial line and packs WORD_BYTES
// consecutive bytes, LSB-byte first, into one word. The word is presented to
// the consumer over a valid/ready handshake. Framing errors, overruns and
// stale partial words (inter-byte timeout) are detected.
//
// Build option:
//   UART_RX_PARITY_EN  when defined the frame is 8E1 and a PARITY state
//                      samples the parity bit. Bad parity pulses
//                      out_parity_err and drops the byte. When undefined the
//                      frame is 8N1 and out_parity_err is tied to 0.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit
//   WORD_BYTES    bytes per output word
//   TIMEOUT_BITS  idle bit periods before a partial word is dropped (0 = off)
//
// Ports:
//   in_clk          system clock
//   in_reset        asynchronous active-high reset
//   rx_serial       asynchronous UART line, idles high
//   in_ready        consumer accepts out_data this cycle
//   out_data        packed word, byte k in bits [8k+7:8k]
//   out_valid       out_data holds an unconsumed word
//   out_frame_err   one-cycle pulse: stop bit sampled low
//   out_parity_err  one-cycle pulse: parity mismatch (parity build only)
//   out_overrun     one-cycle pulse: completed word dropped
//   out_busy        receiving a frame or holding a partial word
// -----------------------------------------------------------------------------
module uart_rx_word_packer #(
  parameter int CLKS_PER_BIT = 640,
  parameter int WORD_BYTES   = 3,
  parameter int TIMEOUT_BITS = 32
) (
  input  logic                    in_clk,
  input  logic                    in_reset,
  input  logic                    rx_serial,
  input  logic                    in_ready,
  output logic [WORD_BYTES*8-1:0] out_data,
  output logic                    out_valid,
  output logic                    out_frame_err,
  output logic                    out_parity_err,
  output logic                    out_overrun,
  output logic                    out_busy
);

  localparam int CNT_W    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W    = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int HALF_BIT = CLKS_PER_BIT / 2;

  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(WORD_BYTES - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser; both flops reset to the idle (high) line level so
  // that leaving reset never looks like a start bit.
  // ---------------------------------------------------------------------------
  logic rx_meta;
  logic rx_s;

  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_serial;
      rx_s    <= rx_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Frame receiver
  // ---------------------------------------------------------------------------
  logic [2:0]       state;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift_reg;
  logic             byte_ok;     // accepted byte waiting to be packed
  logic             start_det;
`ifdef UART_RX_PARITY_EN
  logic             parity_bit;
  logic             parity_err;
`endif

  assign start_det = (state == ST_IDLE) && !rx_s;

  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      state         <= ST_IDLE;
      clk_cnt       <= '0;
      bit_cnt       <= '0;
      shift_reg     <= '0;
      byte_ok       <= 1'b0;
      out_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit    <= 1'b0;
      parity_err    <= 1'b0;
`endif
    end else begin
      byte_ok       <= 1'b0;
      out_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err    <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (!rx_s) begin
            state   <= ST_START;
            clk_cnt <= '0;
            bit_cnt <= '0;
          end
        end

        // Re-check the line in the middle of the start bit so that short
        // glitches are rejected silently.
        ST_START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt <= '0;
            state   <= rx_s ? ST_IDLE : ST_DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        // Sampling point is now mid-bit; each full period lands mid-bit again.
        ST_DATA: begin
          if (clk_cnt == FULL_LAST) begin
            clk_cnt   <= '0;
            shift_reg <= {rx_s, shift_reg[7:1]};
            if (bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state <= ST_PARITY;
`else
              state <= ST_STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (clk_cnt == FULL_LAST) begin
            clk_cnt    <= '0;
            parity_bit <= rx_s;
            state      <= ST_STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
`endif

        ST_STOP: begin
          if (clk_cnt == FULL_LAST) begin
            clk_cnt <= '0;
            if (rx_s) begin
              state <= ST_IDLE;
`ifdef UART_RX_PARITY_EN
              // Even parity: data bits plus parity bit must XOR to zero.
              if (^{shift_reg, parity_bit}) begin
                parity_err <= 1'b1;
              end else begin
                byte_ok <= 1'b1;
              end
`else
              byte_ok <= 1'b1;
`endif
            end else begin
              // A framing error wins over a parity error.
              out_frame_err <= 1'b1;
              state         <= ST_BREAK;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end

        // Line held low past the stop bit: wait for it to return to idle.
        ST_BREAK: begin
          if (rx_s) begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef UART_RX_PARITY_EN
  assign out_parity_err = parity_err;
`else
  assign out_parity_err = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Word packing
  // ---------------------------------------------------------------------------
  logic [IDX_W-1:0]        byte_idx;
  logic [WORD_BYTES*8-1:0] partial_word;
  logic [WORD_BYTES*8-1:0] word_next;
  logic                    last_slot;
  logic                    transfer;
  logic                    can_load;
  logic                    timeout_hit;

  // word_next is the partial word with the incoming byte placed in its slot;
  // on the last slot it is the complete word.
  genvar gi;
  generate
    for (gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
      assign word_next[gi*8 +: 8] = (byte_idx == IDX_W'(gi)) ? shift_reg
                                                             : partial_word[gi*8 +: 8];
    end
  endgenerate

  assign last_slot = (byte_idx == IDX_LAST);
  assign transfer  = out_valid && in_ready;
  assign can_load  = !out_valid || in_ready;

  always_ff @(posedge in_clk or posedge in_reset) begin
    if (in_reset) begin
      byte_idx     <= '0;
      partial_word <= '0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      out_overrun  <= 1'b0;
    end else begin
      out_overrun <= 1'b0;
      if (transfer) begin
        out_valid <= 1'b0;
      end
      if (byte_ok) begin
        partial_word <= word_next;
        if (last_slot) begin
          byte_idx <= '0;
          // A word may load into a register being emptied on this same edge.
          if (can_load) begin
            out_data  <= word_next;
            out_valid <= 1'b1;
          end else begin
            out_overrun <= 1'b1;
          end
        end else begin
          byte_idx <= byte_idx + IDX_W'(1);
        end
      end else if (timeout_hit) begin
        byte_idx <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Inter-byte timeout: counts idle cycles while a partial word is held and
  // silently drops it once the limit is reached.
  // ---------------------------------------------------------------------------
  generate
    if (TIMEOUT_BITS != 0) begin : g_timeout
      localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
      localparam int TO_W     = (TO_LIMIT > 1) ? $clog2(TO_LIMIT + 1) : 1;
      localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_LIMIT - 1);

      logic [TO_W-1:0] to_cnt;
      logic            to_run;

      assign to_run      = (state == ST_IDLE) && (byte_idx != '0) && !start_det;
      assign timeout_hit = to_run && (to_cnt == TO_LAST);

      always_ff @(posedge in_clk or posedge in_reset) begin
        if (in_reset) begin
          to_cnt <= '0;
        end else if (start_det || byte_idx == '0 || timeout_hit) begin
          to_cnt <= '0;
        end else if (to_run) begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  assign out_busy = (state != ST_IDLE) || (byte_idx != '0) || byte_ok;

endmodule

// File: doc/uart_rx_word_packer.md
Name: uart_rx_word_packer

Overview:
- Upstream stage of `main`. Receives 8N1 UART bytes on `rx_serial` and packs WORD_BYTES consecutive bytes, LSB-byte first, into one message word.
- Hands the word to the core over a valid/ready handshake.
- Flags framing errors, overruns and stale partial words (inter-byte timeout).
- Runs in the 73.728 MHz internal clock domain.

Parameters:
- CLKS_PER_BIT, 640, clock cycles per UART bit (73.728 MHz / 115200 baud).
- WORD_BYTES, 3, bytes per output word (3 gives a 24-bit word, matching BPS = 24).
- TIMEOUT_BITS, 32, idle bit-periods after which a partial word is discarded; 0 disables the timeout.

Ports:
- in_clk  input  1  system clock.
- in_reset  input  1  reset; asynchronous, active-high.
- rx_serial  input  1  asynchronous UART line, idles high.
- in_ready  input  1  consumer accepts `out_data` this cycle.
- out_data  output  WORD_BYTES*8  packed word; byte k occupies bits [8k+7:8k].
- out_valid  output  1  `out_data` holds an unconsumed word.
- out_frame_err  output  1  one-cycle pulse: stop bit sampled low.
- out_parity_err  output  1  one-cycle pulse: parity mismatch (only with the optional feature; otherwise tied 0).
- out_overrun  output  1  one-cycle pulse: completed word dropped.
- out_busy  output  1  high while receiving a frame or while a partial word is held.

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs 0; FSM in IDLE; byte index 0; timeout counter 0.
  - Synchroniser flops set to 1.
  - A reset mid-frame or mid-word discards all partial data.
- Input synchronisation: `rx_serial` passes through 2 flops; the FSM uses only the synchronised value `rx_s`.
- FSM states:
  - IDLE: `rx_s`=0 → START, clear bit counter.
  - START: wait CLKS_PER_BIT/2 cycles, then sample `rx_s`.
    - 1 → IDLE (glitch rejected, no error).
    - 0 → DATA.
  - DATA: every CLKS_PER_BIT cycles sample one bit into the shift register, LSB first. After 8 samples → STOP (→ PARITY if the optional feature is enabled).
  - STOP: wait CLKS_PER_BIT cycles, then sample `rx_s`.
    - 1 → byte accepted; go to IDLE on the next cycle.
    - 0 → byte discarded, `out_frame_err` pulses; go to BREAK.
  - BREAK: wait for `rx_s`=1, then IDLE.
- Packing:
  - An accepted byte is written to slot [byte index], and the index increments.
  - On the last slot (index = WORD_BYTES-1) the index wraps to 0 and the word is complete.
- Handshake:
  - Transfer occurs when `out_valid` and `in_ready` are both high at a clock edge; `out_valid` then falls unless a new word loads on the same edge.
  - A completed word loads the output register if `out_valid`=0, or if a transfer happens on the same edge. In both cases `out_valid`=1 on the next edge.
  - A completed word that cannot load is dropped: `out_overrun` pulses, and the held word and `out_valid` are unchanged.
  - `out_data` is stable while `out_valid`=1.
- Latency: `out_valid` rises on the clock edge after the stop-bit sample of the last byte. That is ~9.5 bit periods + 3 cycles after the falling edge of that byte's start bit.
- Timeout (TIMEOUT_BITS ≠ 0):
  - The counter runs while byte index ≠ 0 and the FSM is in IDLE; it clears on any start detection.
  - At TIMEOUT_BITS*CLKS_PER_BIT cycles the byte index resets to 0 and the partial bytes are lost. No pulse is generated.
- Simultaneous events:
  - Framing error on the last slot → word not completed; index unchanged.
  - Reset dominates everything else.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - The frame is 8E1; a PARITY state after DATA samples one bit after 1 bit period.
  - If the XOR of the 8 data bits and the parity bit is ≠ 0, `out_parity_err` pulses in the cycle after the stop-bit sample, and the byte is discarded (the index does not advance).
  - A framing error takes precedence: only `out_frame_err` pulses.
- Undefined: 8N1 frame; `out_parity_err` is constant 0; no PARITY state is present.

Test Plan:
1. Bytes 3F, 03, 33 back-to-back, `in_ready`=1 → one `out_valid` pulse with `out_data`=24'h33033F, 1 cycle after the third stop-bit sample; no error pulses.
2. Bytes FF, E4, B7, then A9, B1, C5 with `in_ready`=0 held → first word 24'hB7E4FF held stable, `out_overrun` pulses once after C5; raising `in_ready` transfers 24'hB7E4FF, and `out_valid` then drops.
3. Byte F1 with the stop bit driven 0, then line high, then bytes 1F, DD, AA → `out_frame_err` pulses once; F1 is discarded; output 24'hAADD1F.
4. Bytes BB, CC, then idle for 40 bit periods, then 12, 34, 56 → partial word dropped by timeout; output 24'h563412 only.
5. 0.3-bit low glitch on `rx_serial` → no state change beyond START/IDLE, no outputs; then `in_reset` pulsed mid-byte during the next frame → all outputs 0, index 0, and the following 3 clean bytes produce a correct word.
6. With UART_RX_PARITY_EN: byte 03 with parity 1 (wrong) → `out_parity_err` pulse and byte dropped; byte 03 with parity 0 → accepted.
